mwrxbuffer_pktfifo: RTL

- Packet-mode receive buffer in the Ethernet MAC hub, rxclk domain.
- Accepts the byte stream from the MAC receive path and stores only complete, error-free packets.
- Serves those packets to the RX arbiter through the rxbuffer read interface (rden / data / datavld / eop / empty).
- Packets with a MAC error, and packets that overflow the buffer, are dropped atomically; the reader never sees partial packets.

---
 rtl/mwrxbuffer_pktfifo.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/mwrxbuffer_pktfifo.sv
// mwrxbuffer_pktfifo: packet-mode receive buffer (rxclk domain).
// Stores only complete, error-free packets. Errored or overflowing packets
// are rolled back atomically by resetting the speculative write pointer to
// the last committed position, so the reader never sees a partial packet.
// Optional macro MWRXBUFFER_STATS_EN adds a saturating dropped-packet counter.
module mwrxbuffer_pktfifo #(
    parameter int DATAWIDTH = 8,
    parameter int ADDRWIDTH = 11
) (
    input  logic                 rxclk,
    input  logic                 reset_n,
    input  logic [DATAWIDTH-1:0] wr_data,
    input  logic                 wr_vld,
    input  logic                 wr_eop,
    input  logic                 wr_err,
    input  logic                 rxbuffer_rden,
    output logic [DATAWIDTH-1:0] rxbuffer_data,
    output logic                 rxbuffer_datavld,
    output logic                 rxbuffer_eop,
    output logic                 rxbuffer_empty
`ifdef MWRXBUFFER_STATS_EN
    ,
    output logic [15:0]          drop_count
`endif
);

    localparam int DEPTH = 1 << ADDRWIDTH;

    // Pointers carry one extra MSB so full and empty are distinguishable.
    typedef logic [ADDRWIDTH:0] ptr_t;

    // Each word holds {eop, data}.
    logic [DATAWIDTH:0]   r_mem [DEPTH];

    ptr_t                 r_wr_commit;
    ptr_t                 r_wr_spec;
    ptr_t                 r_rd_ptr;
    ptr_t                 r_pkt_count;
    logic                 r_overflow;
    logic                 r_datavld;
    logic                 r_eop;
    logic                 r_empty;
    logic [DATAWIDTH-1:0] r_data;

    ptr_t                 w_used;
    ptr_t                 w_pkt_next;
    logic                 w_space;
    logic                 w_wr_en;
    logic                 w_commit;
    logic                 w_drop;
    logic                 w_rd_en;
    logic                 w_pkt_dec;

    // Write/read qualification and packet-count bookkeeping.
    always_comb begin
        // Occupancy includes uncommitted bytes of the packet being received.
        w_used     = r_wr_spec - r_rd_ptr;
        w_space    = (w_used < ptr_t'(DEPTH));
        w_wr_en    = wr_vld & ~r_overflow & w_space;
        // Commit requires the eop byte itself to have landed in memory.
        w_commit   = wr_vld & wr_eop & w_wr_en & ~wr_err;
        w_drop     = wr_vld & wr_eop & ~w_commit;
        // Reads stop at the committed boundary, never at wr_spec.
        w_rd_en    = rxbuffer_rden & (r_rd_ptr != r_wr_commit);
        // A packet leaves the count when its eop word is presented.
        w_pkt_dec  = r_datavld & r_eop;
        w_pkt_next = r_pkt_count;
        if (w_commit && !w_pkt_dec) begin
            w_pkt_next = r_pkt_count + 1'b1;
        end else if (!w_commit && w_pkt_dec) begin
            w_pkt_next = r_pkt_count - 1'b1;
        end
    end

    // Storage array write port (no reset on the RAM contents).
    always_ff @(posedge rxclk) begin
        if (w_wr_en) begin
            r_mem[r_wr_spec[ADDRWIDTH-1:0]] <= {wr_eop, wr_data};
        end
    end

    // Write pointers and overflow flag: advance, commit, or roll back.
    always_ff @(posedge rxclk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_spec   <= '0;
            r_wr_commit <= '0;
            r_overflow  <= 1'b0;
        end else if (w_commit) begin
            r_wr_spec   <= r_wr_spec + 1'b1;
            r_wr_commit <= r_wr_spec + 1'b1;
        end else if (w_drop) begin
            r_wr_spec   <= r_wr_commit;
            r_overflow  <= 1'b0;
        end else if (w_wr_en) begin
            r_wr_spec   <= r_wr_spec + 1'b1;
        end else if (wr_vld) begin
            // Out of space mid-packet: discard everything up to eop.
            r_overflow  <= 1'b1;
        end
    end

    // Read pointer and registered read data (one-cycle latency).
    always_ff @(posedge rxclk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ptr  <= '0;
            r_datavld <= 1'b0;
            r_eop     <= 1'b0;
            r_data    <= '0;
        end else begin
            r_datavld <= w_rd_en;
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                {r_eop, r_data} <= r_mem[r_rd_ptr[ADDRWIDTH-1:0]];
            end
        end
    end

    // Complete-packet count and its registered empty flag.
    always_ff @(posedge rxclk or negedge reset_n) begin
        if (!reset_n) begin
            r_pkt_count <= '0;
            r_empty     <= 1'b1;
        end else begin
            r_pkt_count <= w_pkt_next;
            r_empty     <= (w_pkt_next == '0);
        end
    end

    assign rxbuffer_data    = r_data;
    assign rxbuffer_datavld = r_datavld;
    assign rxbuffer_eop     = r_eop;
    assign rxbuffer_empty   = r_empty;

`ifdef MWRXBUFFER_STATS_EN
    logic [15:0] r_drop_count;

    // Saturating count of packets dropped for error or overflow.
    always_ff @(posedge rxclk or negedge reset_n) begin
        if (!reset_n) begin
            r_drop_count <= '0;
        end else if (w_drop && (r_drop_count != 16'hFFFF)) begin
            r_drop_count <= r_drop_count + 16'd1;
        end
    end

    assign drop_count = r_drop_count;
`endif

endmodule
